// File: rtl/fetch_stage_reg.sv
// Y86-64 fetch stage: PC select, byte-wide instruction memory,
// instruction decode, predicted-PC register and F/D pipeline register.
module fetch_stage_reg #(
  parameter int MEM_DEPTH = 1024,
  parameter int PC_W = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         F_stall,
  input  logic                         D_stall,
  input  logic                         D_bubble,
  input  logic [3:0]                   M_icode,
  input  logic                         M_Cnd,
  input  logic [PC_W-1:0]              M_valA,
  input  logic [3:0]                   W_icode,
  input  logic [PC_W-1:0]              W_valM,
  input  logic                         imem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] imem_addr,
  input  logic [7:0]                   imem_wdata,
  output logic [PC_W-1:0]              f_pc,
  output logic [2:0]                   f_stat,
  output logic [2:0]                   D_stat,
  output logic [3:0]                   D_icode,
  output logic [3:0]                   D_ifun,
  output logic [3:0]                   D_rA,
  output logic [3:0]                   D_rB,
  output logic [PC_W-1:0]              D_valC,
  output logic [PC_W-1:0]              D_valP
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [PC_W-1:0] DEPTH_P = PC_W'(MEM_DEPTH);
  localparam logic [AW:0] DEPTH_A = (AW+1)'(MEM_DEPTH);
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  logic [7:0]      r_mem [MEM_DEPTH];
  logic [PC_W-1:0] r_pred;
  logic [2:0]      r_stat;
  logic [3:0]      r_icode, r_ifun, r_rA, r_rB;
  logic [PC_W-1:0] r_valC, r_valP;

  logic [PC_W-1:0] w_pc;
  logic [PC_W-1:0] w_ba [10];
  logic [7:0]      w_b [10];
  logic [3:0]      w_ic_raw, w_fn_raw;
  logic            w_reg, w_cst, w_adr, w_inv;
  logic [3:0]      w_len;
  logic [PC_W-1:0] w_end;
  logic [63:0]     w_c64;
  logic [3:0]      w_icode, w_ifun, w_rA, w_rB;
  logic [PC_W-1:0] w_valC, w_valP, w_pred;
  logic [2:0]      w_stat;

  // byte writes into instruction memory; never reset
  always_ff @(posedge clk) begin
    if (imem_we && ({1'b0, imem_addr} < DEPTH_A))
      r_mem[imem_addr] <= imem_wdata;
  end

  // fetch PC: mispredict beats return beats prediction
  always_comb begin
    w_pc = r_pred;
    if (M_icode == 4'h7 && !M_Cnd)
      w_pc = M_valA;
    else if (W_icode == 4'h9)
      w_pc = W_valM;
  end

  // ten instruction bytes; out-of-range reads give zero
  always_comb begin
    for (int k = 0; k < 10; k++) begin
      w_ba[k] = w_pc + PC_W'(k);
      w_b[k]  = (w_ba[k] < DEPTH_P) ? r_mem[w_ba[k][AW-1:0]] : 8'h00;
    end
  end

  // decode, length, memory-range check and next-PC prediction
  always_comb begin
    w_ic_raw = w_b[0][7:4];
    w_fn_raw = w_b[0][3:0];
    w_reg = w_ic_raw inside {4'h2, 4'h3, 4'h4, 4'h5,
                             4'h6, 4'hA, 4'hB};
    w_cst = w_ic_raw inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
    w_len = 4'd1 + {3'b0, w_reg} + (w_cst ? 4'd8 : 4'd0);
    w_end = w_pc + PC_W'(w_len) - PC_W'(1);
    w_adr = (w_pc >= DEPTH_P) || (w_end >= DEPTH_P);
    w_inv = (w_ic_raw > 4'hB)
         || ((w_fn_raw != 4'h0) &&
             (w_ic_raw inside {4'h0, 4'h1, 4'h3, 4'h4, 4'h5,
                               4'h8, 4'h9, 4'hA, 4'hB}))
         || ((w_fn_raw > 4'h6) &&
             (w_ic_raw inside {4'h2, 4'h6, 4'h7}));
    w_c64 = w_reg ? {w_b[9], w_b[8], w_b[7], w_b[6],
                     w_b[5], w_b[4], w_b[3], w_b[2]}
                  : {w_b[8], w_b[7], w_b[6], w_b[5],
                     w_b[4], w_b[3], w_b[2], w_b[1]};
    w_icode = w_ic_raw;
    w_ifun  = w_fn_raw;
    w_rA    = w_reg ? w_b[1][7:4] : 4'hF;
    w_rB    = w_reg ? w_b[1][3:0] : 4'hF;
    w_valC  = w_cst ? PC_W'(w_c64) : '0;
    w_valP  = w_pc + PC_W'(w_len);
    if (w_adr) begin
      w_icode = 4'h1;
      w_ifun  = 4'h0;
      w_rA    = 4'hF;
      w_rB    = 4'hF;
      w_valC  = '0;
      w_valP  = w_pc;
    end
    w_pred = (w_icode == 4'h7 || w_icode == 4'h8) ? w_valC : w_valP;
  end

  // fetch status in priority order
  always_comb begin
    if (w_adr)
      w_stat = S_ADR;
    else if (w_inv)
      w_stat = S_INS;
    else if (w_ic_raw == 4'h0)
      w_stat = S_HLT;
    else
      w_stat = S_AOK;
  end

  // predicted-PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pred <= RESET_PC;
    else if (!F_stall)
      r_pred <= w_pred;
  end

  // F/D pipeline register: stall holds, bubble inserts a nop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat  <= S_AOK;
      r_icode <= 4'h1;
      r_ifun  <= 4'h0;
      r_rA    <= 4'hF;
      r_rB    <= 4'hF;
      r_valC  <= '0;
      r_valP  <= '0;
    end else if (!D_stall) begin
      if (D_bubble) begin
        r_stat  <= S_AOK;
        r_icode <= 4'h1;
        r_ifun  <= 4'h0;
        r_rA    <= 4'hF;
        r_rB    <= 4'hF;
        r_valC  <= '0;
        r_valP  <= '0;
      end else begin
        r_stat  <= w_stat;
        r_icode <= w_icode;
        r_ifun  <= w_ifun;
        r_rA    <= w_rA;
        r_rB    <= w_rB;
        r_valC  <= w_valC;
        r_valP  <= w_valP;
      end
    end
  end

  assign f_pc    = w_pc;
  assign f_stat  = w_stat;
  assign D_stat  = r_stat;
  assign D_icode = r_icode;
  assign D_ifun  = r_ifun;
  assign D_rA    = r_rA;
  assign D_rB    = r_rB;
  assign D_valC  = r_valC;
  assign D_valP  = r_valP;

endmodule

// File: tb/tb_fetch_stage_reg.sv
// Bench for fetch_stage_reg: directed fetch scenarios then random
// control/memory traffic against an instruction-level reference model.
module tb_fetch_stage_reg;

  localparam int DEPTH = 1024;
  localparam logic [63:0] DEPTH64 = 64'(DEPTH);

  logic        clk = 0;
  logic        rst_n = 0;
  logic        F_stall = 0, D_stall = 0, D_bubble = 0;
  logic [3:0]  M_icode = 0, W_icode = 0;
  logic        M_Cnd = 0;
  logic [63:0] M_valA = 0, W_valM = 0;
  logic        imem_we = 0;
  logic [9:0]  imem_addr = 0;
  logic [7:0]  imem_wdata = 0;
  logic [63:0] f_pc, D_valC, D_valP;
  logic [2:0]  f_stat, D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;

  fetch_stage_reg #(.MEM_DEPTH(DEPTH), .PC_W(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .f_pc(f_pc), .f_stat(f_stat),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  logic [7:0]  m [DEPTH];
  logic [7:0]  prog [DEPTH];
  logic [63:0] mp;
  logic [2:0]  e_stat;
  logic [3:0]  e_icode, e_ifun, e_rA, e_rB;
  logic [63:0] e_valC, e_valP;
  logic [63:0] e_fpc;
  logic [2:0]  e_fstat;
  logic [3:0]  n_icode, n_ifun, n_rA, n_rB;
  logic [63:0] n_valC, n_valP, n_pred;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rdb(input logic [63:0] a);
    if (a < DEPTH64) return m[int'(a)];
    return 8'h00;
  endfunction

  task automatic set_bubble();
    e_stat = 3'd1; e_icode = 4'h1; e_ifun = 4'h0;
    e_rA = 4'hF; e_rB = 4'hF; e_valC = 64'h0; e_valP = 64'h0;
  endtask

  // instruction-level view: length table, range check, field extraction
  task automatic model_comb();
    logic [7:0] b0, b1;
    logic [3:0] ic, fn;
    bit regs, hasc, adr, bad;
    int len;
    if (M_icode == 4'h7 && !M_Cnd) e_fpc = M_valA;
    else if (W_icode == 4'h9) e_fpc = W_valM;
    else e_fpc = mp;
    b0 = rdb(e_fpc);
    b1 = rdb(e_fpc + 64'd1);
    ic = b0[7:4];
    fn = b0[3:0];
    regs = ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    hasc = ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
    len = 1 + int'(regs) + 8 * int'(hasc);
    adr = (e_fpc >= DEPTH64) || (e_fpc + 64'(len) - 64'd1 >= DEPTH64);
    bad = (ic > 4'hB)
       || (fn != 4'h0 && (ic inside {4'h0, 4'h1, 4'h3, 4'h4, 4'h5,
                                     4'h8, 4'h9, 4'hA, 4'hB}))
       || (fn > 4'h6 && (ic inside {4'h2, 4'h6, 4'h7}));
    n_icode = ic;
    n_ifun = fn;
    n_rA = regs ? b1[7:4] : 4'hF;
    n_rB = regs ? b1[3:0] : 4'hF;
    n_valC = 64'h0;
    if (hasc)
      for (int k = 0; k < 8; k++)
        n_valC = n_valC |
          (64'(rdb(e_fpc + 64'(1 + int'(regs) + k))) << (8 * k));
    n_valP = e_fpc + 64'(len);
    if (adr) begin
      n_icode = 4'h1; n_ifun = 4'h0; n_rA = 4'hF; n_rB = 4'hF;
      n_valC = 64'h0; n_valP = e_fpc;
    end
    if (adr) e_fstat = 3'd3;
    else if (bad) e_fstat = 3'd4;
    else if (ic == 4'h0) e_fstat = 3'd2;
    else e_fstat = 3'd1;
    n_pred = (n_icode == 4'h7 || n_icode == 4'h8) ? n_valC : n_valP;
  endtask

  // one clock: check fetch outputs, clock, update model, check F/D
  task automatic step();
    #1;
    model_comb();
    if (rst_n) begin
      chk("f_pc", f_pc, e_fpc);
      chk("f_stat", 64'(f_stat), 64'(e_fstat));
    end
    @(posedge clk);
    if (rst_n) begin
      if (!F_stall) mp = n_pred;
      if (!D_stall) begin
        if (D_bubble) set_bubble();
        else begin
          e_stat = e_fstat; e_icode = n_icode; e_ifun = n_ifun;
          e_rA = n_rA; e_rB = n_rB; e_valC = n_valC; e_valP = n_valP;
        end
      end
    end
    if (imem_we) m[int'(imem_addr)] = imem_wdata;
    #1;
    chk("D_stat", 64'(D_stat), 64'(e_stat));
    chk("D_icode", 64'(D_icode), 64'(e_icode));
    chk("D_ifun", 64'(D_ifun), 64'(e_ifun));
    chk("D_rA", 64'(D_rA), 64'(e_rA));
    chk("D_rB", 64'(D_rB), 64'(e_rB));
    chk("D_valC", D_valC, e_valC);
    chk("D_valP", D_valP, e_valP);
  endtask

  task automatic areset();
    rst_n = 0;
    mp = 64'h0;
    set_bubble();
    #1;
    model_comb();
    chk("arst_icode", 64'(D_icode), 64'h1);
    chk("arst_stat", 64'(D_stat), 64'h1);
    chk("arst_rA", 64'(D_rA), 64'hF);
    chk("arst_valP", D_valP, 64'h0);
    chk("arst_fpc", f_pc, e_fpc);
  endtask

  task automatic gen_prog();
    int pos, n;
    logic [3:0] ic, fn;
    logic [63:0] c;
    logic [7:0] ib [10];
    pos = 0;
    while (pos < DEPTH) begin
      ic = 4'($urandom_range(0, 11));
      fn = (ic inside {4'h2, 4'h6, 4'h7}) ? 4'($urandom_range(0, 6)) : 4'h0;
      if ($urandom_range(0, 15) == 0) fn = 4'($urandom);
      ib[0] = {ic, fn};
      n = 1;
      if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) begin
        ib[1] = 8'($urandom);
        n = 2;
      end
      if (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8}) begin
        if (ic == 4'h7 || ic == 4'h8) c = 64'($urandom_range(0, DEPTH - 1));
        else c = {32'h0, $urandom};
        for (int k = 0; k < 8; k++) ib[n + k] = c[8 * k +: 8];
        n += 8;
      end
      for (int k = 0; k < n; k++)
        if (pos < DEPTH) begin
          prog[pos] = ib[k];
          pos++;
        end
    end
    for (int k = 0; k < 10; k++) prog[k] = 8'h00;
    prog[0] = 8'h30; prog[1] = 8'hF2; prog[2] = 8'hAA;
    for (int k = 30; k < 39; k++) prog[k] = 8'h00;
    prog[30] = 8'h72; prog[31] = 8'h74;
    for (int k = DEPTH - 5; k < DEPTH; k++) prog[k] = 8'h00;
    prog[DEPTH - 5] = 8'h30; prog[DEPTH - 4] = 8'hF2;
    prog[500] = 8'hC0;
    prog[501] = 8'h00;
  endtask

  initial begin
    logic [63:0] sv_pc, sv_valP;
    for (int k = 0; k < DEPTH; k++) m[k] = 8'h00;
    mp = 64'h0;
    set_bubble();
    gen_prog();

    // load memory while held in reset
    imem_we = 1;
    for (int k = 0; k < DEPTH; k++) begin
      imem_addr = 10'(k);
      imem_wdata = prog[k];
      step();
    end
    imem_we = 0;

    // irmovq at 0
    rst_n = 1;
    step();
    chk("irm_icode", 64'(D_icode), 64'h3);
    chk("irm_rA", 64'(D_rA), 64'hF);
    chk("irm_rB", 64'(D_rB), 64'h2);
    chk("irm_valC", D_valC, 64'hAA);
    chk("irm_valP", D_valP, 64'd10);
    chk("irm_stat", 64'(D_stat), 64'h1);
    #1 chk("irm_pred", f_pc, 64'd10);

    // jl at 30, reached through a return redirect
    W_icode = 4'h9; W_valM = 64'd30;
    step();
    chk("jl_valC", D_valC, 64'h74);
    chk("jl_valP", D_valP, 64'd39);
    W_icode = 4'h0;
    #1 chk("jl_pred", f_pc, 64'h74);
    M_icode = 4'h7; M_Cnd = 0; M_valA = 64'd39;
    #1 chk("mispredict", f_pc, 64'd39);
    W_icode = 4'h9; W_valM = 64'h40;
    #1 chk("both_redirect", f_pc, 64'd39);
    M_icode = 4'h0;
    #1 chk("ret", f_pc, 64'h40);
    step();
    W_icode = 4'h0;

    // stall holds both registers, even with a bubble request
    F_stall = 1; D_stall = 1;
    sv_pc = mp; sv_valP = e_valP;
    step();
    D_bubble = 1;
    step();
    D_bubble = 0;
    step();
    chk("stall_pc", f_pc, sv_pc);
    chk("stall_valP", D_valP, sv_valP);
    F_stall = 0; D_stall = 0;

    D_bubble = 1;
    step();
    chk("bubble_icode", 64'(D_icode), 64'h1);
    chk("bubble_rA", 64'(D_rA), 64'hF);
    chk("bubble_rB", 64'(D_rB), 64'hF);
    chk("bubble_valP", D_valP, 64'h0);
    D_bubble = 0;

    // status cases
    W_icode = 4'h9; W_valM = 64'(DEPTH - 5);
    step();
    chk("adr_stat", 64'(D_stat), 64'h3);
    chk("adr_icode", 64'(D_icode), 64'h1);
    chk("adr_valP", D_valP, 64'(DEPTH - 5));
    W_valM = 64'd500;
    step();
    chk("ins_stat", 64'(D_stat), 64'h4);
    W_valM = 64'd501;
    step();
    chk("hlt_stat", 64'(D_stat), 64'h2);
    chk("hlt_valP", D_valP, 64'd502);

    // nop in the very last byte fits; one past the end does not
    imem_we = 1; imem_addr = 10'(DEPTH - 1); imem_wdata = 8'h10;
    step();
    imem_we = 0;
    W_valM = 64'(DEPTH - 1);
    step();
    chk("last_stat", 64'(D_stat), 64'h1);
    chk("last_valP", D_valP, 64'(DEPTH));
    W_valM = 64'(DEPTH);
    #1 chk("oob_fstat", 64'(f_stat), 64'h3);
    step();
    W_icode = 4'h0;

    // asynchronous reset in the middle of a stall
    F_stall = 1; D_stall = 1;
    step();
    areset();
    step();
    rst_n = 1; F_stall = 0; D_stall = 0;

    // random traffic
    repeat (2000) begin
      rst_n = 1;
      F_stall = ($urandom_range(0, 7) == 0);
      D_stall = ($urandom_range(0, 7) == 0);
      D_bubble = ($urandom_range(0, 7) == 0);
      M_icode = ($urandom_range(0, 3) == 0) ? 4'h7 : 4'($urandom);
      M_Cnd = 1'($urandom);
      M_valA = 64'($urandom_range(0, DEPTH + 8));
      W_icode = ($urandom_range(0, 3) == 0) ? 4'h9 : 4'($urandom);
      W_valM = 64'($urandom_range(0, DEPTH + 8));
      imem_we = ($urandom_range(0, 9) == 0);
      imem_addr = 10'($urandom_range(0, DEPTH - 1));
      imem_wdata = 8'($urandom);
      if ($urandom_range(0, 99) == 0) areset();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
